// File: rtl/anabellek_hakemi.sv
// anabellek_hakemi: round-robin arbiter giving the instruction and data caches turns on the single main-memory port.
module anabellek_hakemi #(
    parameter int ADRES_BIT = 32,
    parameter int BLOK_BIT  = 128
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [ADRES_BIT-1:0] buyruk_okuma_istek_adres_i,
    input  logic                 buyruk_okuma_istek_gecerli_i,
    output logic [BLOK_BIT-1:0]  buyruk_okuma_veri_blok_o,
    output logic                 buyruk_okuma_istek_hazir_o,
    input  logic [ADRES_BIT-1:0] veri_istek_adres_i,
    input  logic                 veri_istek_gecerli_i,
    input  logic                 veri_istek_yaz_i,
    input  logic [BLOK_BIT-1:0]  veri_yazma_veri_blok_i,
    output logic [BLOK_BIT-1:0]  veri_okuma_veri_blok_o,
    output logic                 veri_istek_hazir_o,
    output logic [ADRES_BIT-1:0] anabellek_istek_adres_o,
    output logic                 anabellek_istek_gecerli_o,
    output logic                 anabellek_istek_yaz_o,
    output logic [BLOK_BIT-1:0]  anabellek_yazma_veri_blok_o,
    input  logic [BLOK_BIT-1:0]  anabellek_okuma_veri_blok_i,
    input  logic                 anabellek_istek_hazir_i
);
    typedef enum logic [1:0] {BOSTA, BUYRUK_SERVIS, VERI_SERVIS} durum_t;
    durum_t durum, durum_n;
    logic son_hizmet, son_hizmet_n, yaz_r, yaz_n;
    logic [ADRES_BIT-1:0] adres_r, adres_n;
    logic [BLOK_BIT-1:0] yazma_blok_r, yazma_blok_n;
    logic buyruk_sec, veri_sec, buyruk_bitti, veri_bitti;
    // son_hizmet names the last owner; on a tie the other side wins
    assign buyruk_sec = buyruk_okuma_istek_gecerli_i && (!veri_istek_gecerli_i || son_hizmet);
    assign veri_sec = veri_istek_gecerli_i && (!buyruk_okuma_istek_gecerli_i || !son_hizmet);
    assign buyruk_bitti = durum == BUYRUK_SERVIS && anabellek_istek_hazir_i;
    assign veri_bitti = durum == VERI_SERVIS && anabellek_istek_hazir_i;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            durum <= BOSTA;
            son_hizmet <= 1'b1;
            adres_r <= '0;
            yaz_r <= 1'b0;
            yazma_blok_r <= '0;
        end else begin
            durum <= durum_n;
            son_hizmet <= son_hizmet_n;
            adres_r <= adres_n;
            yaz_r <= yaz_n;
            yazma_blok_r <= yazma_blok_n;
        end
    end
    always_comb begin
        durum_n = durum;
        son_hizmet_n = son_hizmet;
        adres_n = adres_r;
        yaz_n = yaz_r;
        yazma_blok_n = yazma_blok_r;
        if (durum == BOSTA) begin
            if (buyruk_sec) begin
                durum_n = BUYRUK_SERVIS;
                adres_n = buyruk_okuma_istek_adres_i;
                yaz_n = 1'b0;
            end else if (veri_sec) begin
                durum_n = VERI_SERVIS;
                adres_n = veri_istek_adres_i;
                yaz_n = veri_istek_yaz_i;
                yazma_blok_n = veri_yazma_veri_blok_i;
            end
        end else if (anabellek_istek_hazir_i) begin
            durum_n = BOSTA;
            son_hizmet_n = durum == VERI_SERVIS;
        end
    end
    assign anabellek_istek_gecerli_o = durum != BOSTA;
    assign anabellek_istek_adres_o = adres_r;
    assign anabellek_istek_yaz_o = anabellek_istek_gecerli_o && yaz_r;
    assign anabellek_yazma_veri_blok_o = yazma_blok_r;
    assign buyruk_okuma_istek_hazir_o = buyruk_bitti;
    assign veri_istek_hazir_o = veri_bitti;
    assign buyruk_okuma_veri_blok_o = buyruk_bitti ? anabellek_okuma_veri_blok_i : '0;
    // a write-back returns no data
    assign veri_okuma_veri_blok_o = (veri_bitti && !yaz_r) ? anabellek_okuma_veri_blok_i : '0;
endmodule

// File: doc/anabellek_hakemi.md
Name: anabellek_hakemi

Overview:
Arbitrates the single main-memory controller port between the instruction cache controller (block reads only) and the data cache controller (block reads and write-backs). Sits between both cache controllers and main_memory_controller. Serves one transaction at a time, latches each granted request, and routes the returned block and ready pulse to the owner only. Uses round-robin priority so neither cache can starve the other.

Parameters:
ADRES_BIT, 32, address width of every request.
BLOK_BIT, 128, cache block width; one transaction moves one block.

Ports:
clk_i  input  1  clock; all state updates on rising edge.
rst_i  input  1  synchronous, active-high reset.
buyruk_okuma_istek_adres_i  input  ADRES_BIT  instruction cache miss address.
buyruk_okuma_istek_gecerli_i  input  1  instruction cache read request; held high until its hazir pulse.
buyruk_okuma_veri_blok_o  output  BLOK_BIT  block returned to instruction cache.
buyruk_okuma_istek_hazir_o  output  1  one-cycle completion pulse to instruction cache.
veri_istek_adres_i  input  ADRES_BIT  data cache request address.
veri_istek_gecerli_i  input  1  data cache request; held high until its hazir pulse.
veri_istek_yaz_i  input  1  1 = write-back, 0 = block read.
veri_yazma_veri_blok_i  input  BLOK_BIT  write-back block.
veri_okuma_veri_blok_o  output  BLOK_BIT  block returned to data cache.
veri_istek_hazir_o  output  1  one-cycle completion pulse to data cache.
anabellek_istek_adres_o  output  ADRES_BIT  latched address to memory controller.
anabellek_istek_gecerli_o  output  1  request valid to memory controller.
anabellek_istek_yaz_o  output  1  latched write enable.
anabellek_yazma_veri_blok_o  output  BLOK_BIT  latched write block.
anabellek_okuma_veri_blok_i  input  BLOK_BIT  block from memory controller.
anabellek_istek_hazir_i  input  1  one-cycle completion from memory controller.

Behaviour:
- States: BOSTA, BUYRUK_SERVIS, VERI_SERVIS. Registers: durum, son_hizmet (0 = instruction, 1 = data), adres_r, yaz_r, yazma_blok_r.
- Reset (rst_i high at edge): durum = BOSTA, son_hizmet = 1 (instruction wins the first tie), adres_r/yazma_blok_r = 0, yaz_r = 0. In-flight transaction is abandoned; main_memory_controller shares rst_i.
- Outputs in reset/BOSTA: anabellek_istek_gecerli_o = 0, both hazir_o = 0, both veri_blok_o = 0, anabellek_istek_yaz_o = 0.
- BOSTA, only instruction request: latch its address, yaz_r = 0, go BUYRUK_SERVIS.
- BOSTA, only data request: latch address, yaz, write block; go VERI_SERVIS.
- BOSTA, both requests: grant the requester not equal to son_hizmet. Loser stays pending with gecerli high.
- BUYRUK_SERVIS/VERI_SERVIS: anabellek_istek_gecerli_o = 1; address, yaz and write block come only from latched registers, so input changes are ignored. The latency from request to grant is 1 cycle: a request seen in BOSTA at cycle N drives memory valid from cycle N+1.
- Completion: when anabellek_istek_hazir_i = 1 in a SERVIS state, in the same cycle the owner's hazir_o = 1 and its veri_blok_o = anabellek_okuma_veri_blok_i (combinational pass-through). The other requester's hazir_o stays 0 and its block output stays 0. On that edge durum = BOSTA and son_hizmet = owner. For a write-back, veri_istek_hazir_o pulses and veri_okuma_veri_blok_o stays 0.
- Requesters deassert gecerli the cycle after hazir. A pending loser is granted in the first BOSTA cycle after completion. The back-to-back gap is therefore one BOSTA cycle.
- anabellek_istek_hazir_i while in BOSTA is ignored; no hazir_o is generated.
- A requester dropping gecerli mid-service does not cancel the transaction. It completes, and the hazir pulse is still issued.
- Memory valid stays high for an unbounded time; there is no timeout.

Test Plan:
- Reset then instruction read 0x0000_1230, memory hazir after 3 cycles with block 0xA5…A5 -> memory valid high 3 cycles; buyruk_okuma_istek_hazir_o pulses 1 cycle with block A5…A5; veri_istek_hazir_o stays 0.
- Both requests in the same cycle after reset (instruction 0x100, data read 0x200) -> instruction served first, data granted one BOSTA cycle after its completion, with memory address 0x200.
- Instruction requests continuously while data is pending -> service order alternates I, D, I, D; no requester is served twice in a row while the other is waiting.
- Data write-back to 0x0000_0400 with block 0xDEAD…BEEF; change inputs during service -> memory sees yaz=1, address 0x400 and the original block throughout; veri_istek_hazir_o pulses; veri_okuma_veri_blok_o = 0.
- rst_i asserted mid VERI_SERVIS -> next cycle: memory valid 0, state BOSTA, son_hizmet = 1; a new instruction request is granted normally.
- Spurious anabellek_istek_hazir_i in BOSTA -> no hazir_o pulse, no state change.
